// File: rtl/elastic_buffer_read_processor_if.sv
// Buffer-facing and downstream-facing signals of the elastic buffer read stage.
// The master modport is the read processor; the slave modport is the
// environment (buffer head on one side, downstream consumer on the other).
interface elastic_buffer_read_processor_if #(
  parameter int BUFFER_WIDTH = 13,
  parameter int ADDR_WIDTH   = 4
);
  logic [BUFFER_WIDTH-1:0] rd_data;
  logic                    buff_empty;
  logic [ADDR_WIDTH:0]     occupancy;
  logic                    read_en;
  logic [BUFFER_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    skp_add_active;

  modport master (
    input  rd_data,
    input  buff_empty,
    input  occupancy,
    output read_en,
    output out_data,
    output out_valid,
    output skp_add_active
  );

  modport slave (
    output rd_data,
    output buff_empty,
    output occupancy,
    input  read_en,
    input  out_data,
    input  out_valid,
    input  skp_add_active
  );
endinterface

// File: rtl/elastic_buffer_read_processor.sv
// Read-side control of the RX elastic buffer. Pops show-ahead words and
// forwards them through one output register. When occupancy runs low, a SKP
// popped at symbol index 0 (or index 4 after one burst) is replicated
// INSERT_LEN times while the read pointer is stalled, padding the stream.
module elastic_buffer_read_processor #(
  parameter int BUFFER_WIDTH = 13,
  parameter int ADDR_WIDTH   = 4,
  parameter int LOW_THRESH   = 4,
  parameter int INSERT_LEN   = 4,
  parameter int MAX_INSERTED = 8
) (
  input  logic rx_clk,
  input  logic rx_rst,
  input  logic elstc_buff_en,
  elastic_buffer_read_processor_if.master bus
);

  localparam logic [8:0]          SKP_SYM      = 9'b110011001;
  localparam logic [3:0]          INS_LEN_C    = 4'(INSERT_LEN);
  localparam logic [3:0]          INS_LAST_C   = 4'(INSERT_LEN - 1);
  localparam logic [3:0]          MAX_INS_C    = 4'(MAX_INSERTED);
  localparam logic [ADDR_WIDTH:0] LOW_THRESH_C = (ADDR_WIDTH+1)'(LOW_THRESH);

  typedef enum logic [0:0] {
    ST_PASS   = 1'b0,
    ST_INSERT = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [BUFFER_WIDTH-1:0] out_data_reg, out_data_next;
  logic                    out_valid_reg, out_valid_next;
  logic [BUFFER_WIDTH-1:0] hold_word_reg, hold_word_next;
  logic [3:0]              ins_cnt_reg, ins_cnt_next;
  logic [3:0]              inserted_count_reg, inserted_count_next;

  logic       is_skp;
  logic [3:0] idx;
  logic       add_rqst;
  logic       pass_pop;
  logic       insert_trigger;
  logic       os_end;

  // Decode the head-of-buffer word and the low-occupancy request.
  assign is_skp   = (bus.rd_data[8:0] == SKP_SYM);
  assign idx      = bus.rd_data[12:9];
  assign add_rqst = (bus.occupancy < LOW_THRESH_C);

  // A pop only ever happens from PASS; INSERT holds the read pointer.
  assign pass_pop = elstc_buff_en & ~bus.buff_empty & (state_reg == ST_PASS);

  // Burst at idx 0 of a fresh ordered set, or a second burst at idx 4.
  assign insert_trigger = pass_pop & is_skp & add_rqst &
                          (inserted_count_reg < MAX_INS_C) &
                          (((idx == 4'd0) & (inserted_count_reg == 4'd0)) |
                           ((idx == 4'd4) & (inserted_count_reg == INS_LEN_C)));

  // A non-SKP word or the last SKP slot closes the ordered set.
  assign os_end = ~is_skp | (idx == 4'd15);

  // Pop strobe is held low for the whole time reset is asserted.
  assign bus.read_en        = pass_pop & rx_rst;
  assign bus.out_data       = out_data_reg;
  assign bus.out_valid      = out_valid_reg;
  assign bus.skp_add_active = (state_reg == ST_INSERT);

  // Next-state and datapath decisions for the PASS/INSERT machine.
  always_comb begin
    state_next          = state_reg;
    out_data_next       = out_data_reg;
    out_valid_next      = 1'b0;
    hold_word_next      = hold_word_reg;
    ins_cnt_next        = ins_cnt_reg;
    inserted_count_next = inserted_count_reg;

    if (!elstc_buff_en) begin
      // Disable aborts any burst in progress and forgets the set history.
      state_next          = ST_PASS;
      ins_cnt_next        = 4'd0;
      inserted_count_next = 4'd0;
    end else begin
      case (state_reg)
        ST_PASS: begin
          if (pass_pop) begin
            out_data_next  = bus.rd_data;
            out_valid_next = 1'b1;
          end
          if (insert_trigger) begin
            hold_word_next = bus.rd_data;
            ins_cnt_next   = 4'd0;
            state_next     = ST_INSERT;
          end else if (pass_pop && os_end) begin
            inserted_count_next = 4'd0;
          end
        end
        ST_INSERT: begin
          out_data_next  = hold_word_reg;
          out_valid_next = 1'b1;
          ins_cnt_next   = ins_cnt_reg + 4'd1;
          if (ins_cnt_reg == INS_LAST_C) begin
            state_next          = ST_PASS;
            inserted_count_next = inserted_count_reg + INS_LEN_C;
          end
        end
        default: begin
          state_next = ST_PASS;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      state_reg          <= ST_PASS;
      out_data_reg       <= '0;
      out_valid_reg      <= 1'b0;
      hold_word_reg      <= '0;
      ins_cnt_reg        <= 4'd0;
      inserted_count_reg <= 4'd0;
    end else begin
      state_reg          <= state_next;
      out_data_reg       <= out_data_next;
      out_valid_reg      <= out_valid_next;
      hold_word_reg      <= hold_word_next;
      ins_cnt_reg        <= ins_cnt_next;
      inserted_count_reg <= inserted_count_next;
    end
  end

endmodule

// File: tb/tb_elastic_buffer_read_processor.sv
// Bench for elastic_buffer_read_processor: a queue models the buffer, and
// every word loaded is pushed onto an expected-output queue together with
// the number of SKP copies that word should produce downstream.
module tb_elastic_buffer_read_processor;

  logic rx_clk = 1'b0;
  logic rx_rst;
  logic elstc_buff_en;

  elastic_buffer_read_processor_if #(.BUFFER_WIDTH(13), .ADDR_WIDTH(4)) bus ();

  elastic_buffer_read_processor #(
    .BUFFER_WIDTH(13), .ADDR_WIDTH(4), .LOW_THRESH(4),
    .INSERT_LEN(4), .MAX_INSERTED(8)
  ) dut (
    .rx_clk        (rx_clk),
    .rx_rst        (rx_rst),
    .elstc_buff_en (elstc_buff_en),
    .bus           (bus)
  );

  always #5 rx_clk = ~rx_clk;

  logic [12:0] buf_q[$];
  logic [12:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          ins_cycles = 0;
  logic        force_empty = 1'b0;
  logic        chk_rd_high = 1'b0;
  logic        last_rd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] skp(input int i);
    logic [3:0] f;
    f = i[3:0];
    return {f, 9'b110011001};
  endfunction

  function automatic logic [12:0] ts(input int i);
    logic [3:0] f;
    f = i[3:0];
    return {f, 9'h04A};
  endfunction

  task automatic drive();
    bus.rd_data    = (buf_q.size() != 0) ? buf_q[0] : 13'h0;
    bus.buff_empty = (buf_q.size() == 0) | force_empty;
  endtask

  task automatic send_word(input logic [12:0] w, input int copies);
    buf_q.push_back(w);
    for (int k = 0; k <= copies; k++) exp_q.push_back(w);
  endtask

  // One clock: sample the pop strobe mid-cycle, then pop and score the
  // registered output just after the edge.
  task automatic tick();
    logic [12:0] e;
    @(negedge rx_clk);
    last_rd = bus.read_en;
    if (bus.skp_add_active) begin
      ins_cycles++;
      check_val("rd_en_in_insert", {31'b0, bus.read_en}, 32'd0);
    end
    if (chk_rd_high && buf_q.size() != 0)
      check_val("rd_en_stream", {31'b0, bus.read_en}, 32'd1);
    @(posedge rx_clk);
    #1;
    if (last_rd && buf_q.size() != 0) void'(buf_q.pop_front());
    if (bus.out_valid) begin
      check_val("exp_available", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("[%0t] out %h exp %h skp_add=%0b", $time, bus.out_data, e, bus.skp_add_active);
        check_val("out_data", {19'b0, bus.out_data}, {19'b0, e});
      end
    end
    drive();
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while ((buf_q.size() != 0 || exp_q.size() != 0) && cnt < 200) begin
      tick();
      cnt++;
    end
    repeat (3) tick();
    check_val("drain_done", buf_q.size() + exp_q.size(), 32'd0);
  endtask

  initial begin
    int cnt;
    rx_rst        = 1'b0;
    elstc_buff_en = 1'b1;
    bus.occupancy = 5'd10;
    send_word(ts(0), 0);
    drive();
    #3;
    check_val("rst_read_en",   {31'b0, bus.read_en},        32'd0);
    check_val("rst_out_valid", {31'b0, bus.out_valid},      32'd0);
    check_val("rst_out_data",  {19'b0, bus.out_data},       32'd0);
    check_val("rst_skp_add",   {31'b0, bus.skp_add_active}, 32'd0);
    @(posedge rx_clk);
    #1;
    rx_rst = 1'b1;
    drive();

    // Plain TS stream at high occupancy: pop every cycle, no insertion.
    for (int i = 1; i < 16; i++) send_word(ts(i), 0);
    drive();
    chk_rd_high = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    chk_rd_high = 1'b0;
    drain();
    check_val("s1_ins_cycles", ins_cycles, 32'd0);

    // Low occupancy, SKP set idx 0..3: one burst after idx 0.
    bus.occupancy = 5'd2;
    ins_cycles = 0;
    send_word(skp(0), 4);
    for (int i = 1; i < 4; i++) send_word(skp(i), 0);
    send_word(ts(5), 0);
    drive();
    drain();
    check_val("s2_ins_cycles", ins_cycles, 32'd4);

    // SKP set idx 0..7: bursts after idx 0 and idx 4, then capped.
    ins_cycles = 0;
    send_word(skp(0), 4);
    for (int i = 1; i < 4; i++) send_word(skp(i), 0);
    send_word(skp(4), 4);
    for (int i = 5; i < 8; i++) send_word(skp(i), 0);
    for (int i = 0; i < 4; i++) send_word(skp(i), 0);
    drive();
    drain();
    check_val("s3_ins_cycles", ins_cycles, 32'd8);

    // A non-SKP word clears the count, so the next set gets a burst again.
    ins_cycles = 0;
    send_word(ts(0), 0);
    send_word(skp(0), 4);
    for (int i = 1; i < 4; i++) send_word(skp(i), 0);
    send_word(ts(1), 0);
    drive();
    drain();
    check_val("s3b_ins_cycles", ins_cycles, 32'd4);

    // Empty pulse mid-stream: two bubbles, no loss or duplication.
    bus.occupancy = 5'd10;
    for (int i = 0; i < 8; i++) send_word(ts(i), 0);
    drive();
    repeat (3) tick();
    force_empty = 1'b1;
    drive();
    for (int k = 0; k < 2; k++) begin
      tick();
      check_val("empty_read_en",   {31'b0, last_rd},       32'd0);
      check_val("empty_out_valid", {31'b0, bus.out_valid}, 32'd0);
    end
    force_empty = 1'b0;
    drive();
    drain();

    // Disable at the second insert cycle: only one copy escapes.
    bus.occupancy = 5'd2;
    send_word(skp(0), 1);
    drive();
    cnt = 0;
    tick();
    while (!bus.skp_add_active && cnt < 10) begin
      tick();
      cnt++;
    end
    check_val("s5_insert_seen", {31'b0, bus.skp_add_active}, 32'd1);
    tick();
    elstc_buff_en = 1'b0;
    tick();
    check_val("dis_read_en",   {31'b0, last_rd},            32'd0);
    check_val("dis_out_valid", {31'b0, bus.out_valid},      32'd0);
    check_val("dis_skp_add",   {31'b0, bus.skp_add_active}, 32'd0);
    elstc_buff_en = 1'b1;
    bus.occupancy = 5'd10;
    ins_cycles = 0;
    for (int i = 1; i < 4; i++) send_word(skp(i), 0);
    for (int i = 0; i < 4; i++) send_word(ts(i), 0);
    drive();
    drain();
    check_val("s5_ins_cycles", ins_cycles, 32'd0);

    // Reset mid-burst: outputs clear immediately, then plain pass-through.
    bus.occupancy = 5'd2;
    send_word(skp(0), 1);
    drive();
    tick();
    tick();
    send_word(ts(9), 0);
    drive();
    rx_rst = 1'b0;
    #1;
    check_val("mid_rst_out_valid", {31'b0, bus.out_valid},      32'd0);
    check_val("mid_rst_out_data",  {19'b0, bus.out_data},       32'd0);
    check_val("mid_rst_read_en",   {31'b0, bus.read_en},        32'd0);
    check_val("mid_rst_skp_add",   {31'b0, bus.skp_add_active}, 32'd0);
    @(posedge rx_clk);
    #1;
    check_val("mid_rst_hold_valid", {31'b0, bus.out_valid}, 32'd0);
    rx_rst = 1'b1;
    bus.occupancy = 5'd10;
    ins_cycles = 0;
    for (int i = 10; i < 13; i++) send_word(ts(i), 0);
    drive();
    drain();
    check_val("s6_ins_cycles", ins_cycles, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
